// File: rtl/button_conditioner.sv
// Three-channel push-button conditioner: 2-flop synchroniser, stability-count debounce, rising-edge pulse.
// Optional AUTOREPEAT_EN macro adds press-and-hold auto-repeat on the increment channel.
module button_conditioner #(
  parameter int STABLE_TICKS = 20,
  parameter int CNT_W        = 8,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 200
) (
  input  logic clock,
  input  logic reset,
  input  logic set,
  input  logic increment,
  input  logic start,
  output logic db_set,
  output logic db_increment,
  output logic db_start,
  output logic p_set,
  output logic p_increment,
  output logic p_start
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(STABLE_TICKS - 1);

  if (STABLE_TICKS < 2 || STABLE_TICKS > (2**CNT_W) - 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1)
  begin : g_bad_param
    $error("button_conditioner: illegal parameter value");
  end

  // channel index: 0 = set, 1 = increment, 2 = start
  logic [2:0]       w_raw;
  logic [2:0]       r_sync1;
  logic [2:0]       r_sync2;
  logic [2:0]       r_db;
  logic [2:0]       r_p;
  logic [CNT_W-1:0] r_cnt [3];
  logic [2:0]       w_db_next;
  logic [2:0]       w_rise;
  logic             w_rpt_fire;

  assign w_raw = {start, increment, set};

  always_comb begin
    w_db_next = r_db;
    for (int i = 0; i < 3; i++) begin
      if (r_sync2[i] != r_db[i] && r_cnt[i] == LP_LAST) w_db_next[i] = r_sync2[i];
    end
  end

  assign w_rise = w_db_next & ~r_db;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_p     <= '0;
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_db    <= w_db_next;
      r_p     <= {w_rise[2], w_rise[1] | w_rpt_fire, w_rise[0]};
      for (int i = 0; i < 3; i++) begin
        // counter restarts whenever the input agrees with the debounced level
        if (r_sync2[i] == r_db[i] || r_cnt[i] == LP_LAST) r_cnt[i] <= '0;
        else                                              r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end

`ifdef AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = (RPT_MAX < 2) ? 1 : $clog2(RPT_MAX);
  localparam logic [RPT_W-1:0] LP_DELAY = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] LP_RATE  = RPT_W'(REPEAT_RATE - 1);

  logic [RPT_W-1:0] r_rpt;

  // suppress a repeat on the edge where the debounced level falls
  assign w_rpt_fire = r_db[1] & w_db_next[1] & (r_rpt == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rpt <= '0;
    end else if (!w_db_next[1]) begin
      r_rpt <= '0;
    end else if (w_rise[1]) begin
      r_rpt <= LP_DELAY;
    end else if (r_rpt == '0) begin
      r_rpt <= LP_RATE;
    end else begin
      r_rpt <= r_rpt - 1'b1;
    end
  end
`else
  assign w_rpt_fire = 1'b0;
`endif

  assign db_set       = r_db[0];
  assign db_increment = r_db[1];
  assign db_start     = r_db[2];
  assign p_set        = r_p[0];
  assign p_increment  = r_p[1];
  assign p_start      = r_p[2];

endmodule

// File: tb/tb_button_conditioner.sv
// Directed self-checking bench for button_conditioner (STABLE_TICKS=4, REPEAT_DELAY=10, REPEAT_RATE=3).
// Build with +define+AUTOREPEAT_EN to also cover increment auto-repeat.
module tb_button_conditioner;

  logic clock = 1'b0;
  logic reset;
  logic set, increment, start;
  logic db_set, db_increment, db_start;
  logic p_set, p_increment, p_start;

  int n_checks = 0;
  int n_errors = 0;

`ifdef AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  button_conditioner #(
    .STABLE_TICKS(4),
    .CNT_W       (8),
    .REPEAT_DELAY(10),
    .REPEAT_RATE (3)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .set         (set),
    .increment   (increment),
    .start       (start),
    .db_set      (db_set),
    .db_increment(db_increment),
    .db_start    (db_start),
    .p_set       (p_set),
    .p_increment (p_increment),
    .p_start     (p_start)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic exp_db, exp_p;
    int   o;

    // reset with all buttons held high
    reset = 1'b0; set = 1'b1; increment = 1'b1; start = 1'b1;
    #23;
    chk("reset_outs", {db_set, db_increment, db_start, p_set, p_increment, p_start}, 32'h0);
    tick();
    chk("reset_outs2", {db_set, db_increment, db_start, p_set, p_increment, p_start}, 32'h0);
    set = 1'b0; increment = 1'b0;
    tick();
    reset = 1'b1;

    // start held through release: fresh press at edge 6
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("rel_db_start_k%0d", k), db_start, k >= 6);
      chk($sformatf("rel_p_start_k%0d", k), p_start, k == 6);
    end
    start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("fall_db_start_k%0d", k), db_start, k < 6);
      chk($sformatf("fall_p_start_k%0d", k), p_start, 1'b0);
    end
    idle(3);

    // increment press held, then released; repeats only with AUTOREPEAT_EN
    increment = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      exp_db = (k >= 6) && (k <= 36);
      o      = k - 6;
      exp_p  = exp_db && ((o == 0) || (AR && o >= 10 && ((o - 10) % 3) == 0));
      chk($sformatf("inc_db_k%0d", k), db_increment, exp_db);
      chk($sformatf("inc_p_k%0d", k), p_increment, exp_p);
      chk($sformatf("inc_others_k%0d", k), {p_set, p_start, db_set, db_start}, 32'h0);
      if (k == 31) increment = 1'b0;
    end
    idle(3);

    // bounce on set: 1,1,0,0,1,1,0,0 then steady 1 from step 9
    for (int j = 1; j <= 16; j++) begin
      set = (j >= 9) ? 1'b1 : ((((j - 1) / 2) % 2) == 0);
      tick();
      chk($sformatf("bnc_db_set_j%0d", j), db_set, j >= 14);
      chk($sformatf("bnc_p_set_j%0d", j), p_set, j == 14);
    end
    set = 1'b0;
    idle(8);
    chk("bnc_db_set_off", db_set, 1'b0);

    // simultaneous set and start
    set = 1'b1; start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("sim_p_k%0d", k), {p_set, p_start}, (k == 6) ? 32'h3 : 32'h0);
      chk($sformatf("sim_db_k%0d", k), {db_set, db_start}, (k >= 6) ? 32'h3 : 32'h0);
      chk($sformatf("sim_inc_k%0d", k), {db_increment, p_increment}, 32'h0);
    end
    set = 1'b0; start = 1'b0;
    idle(8);
    chk("sim_off", {db_set, db_start}, 32'h0);

    // reset mid-count with start held
    start = 1'b1;
    idle(2);
    reset = 1'b0;
    #3;
    chk("mid_reset_outs", {db_set, db_increment, db_start, p_set, p_increment, p_start}, 32'h0);
    tick();
    reset = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("mid_db_start_k%0d", k), db_start, k >= 6);
      chk($sformatf("mid_p_start_k%0d", k), p_start, k == 6);
    end
    start = 1'b0;
    idle(8);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
